bp_pattern_table: RTL and testbench
===================================

// Module: bp_pattern_table
// PURPOSE
//  Gshare pattern history table: reader/consumer of the global history register (GHR) output.
//  DEC-stage lookup: index = PC[BPRED_WIDTH+1:2] ^ GHR; 2-bit counter MSB drives i_Prediction of the GHR.
//  In-flight FIFO carries {index, prediction} to EX; branch resolution trains the counter, flags mispredict.
// PARAMETERS
//  BPRED_WIDTH     9  index/GHR width; table holds 2**BPRED_WIDTH 2-bit counters
//  INFLIGHT_DEPTH  4  max unresolved branches between DEC and EX (power of 2, >=2)
// PORTS
//  i_Clk                 in   1            clock; all state on rising edge
//  i_Reset               in   1            synchronous, active-high reset
//  i_DEC_Is_Branch       in   1            lookup request: branch in DEC stage
//  i_DEC_PC              in   32           PC of DEC-stage branch
//  i_Global_History      in   BPRED_WIDTH  GHR output, used in the lookup index
//  o_Prediction          out  1            predicted direction (1 = taken)
//  o_Pred_Valid          out  1            lookup accepted and pushed this cycle
//  o_Stall               out  1            FIFO full or table initialising; DEC must hold
//  o_Ready               out  1            init sweep complete
//  i_ALU_Branch_Valid    in   1            branch resolved in EX this cycle
//  i_ALU_Branch_Outcome  in   1            actual direction (1 = taken)
//  i_Flush               in   1            squash all younger in-flight branches
//  o_Mispredict          out  1            resolved outcome != stored prediction (combinational)
// BEHAVIOUR
//  FSM INIT -> RUN. Reset (any state, any cycle): state=INIT, sweep ptr=0, FIFO cleared.
//  INIT: write 2'b10 (weakly taken) to entry ptr each cycle; ptr==2**BPRED_WIDTH-1 -> RUN next cycle.
//  INIT lasts exactly 2**BPRED_WIDTH cycles; o_Ready=0, o_Stall=1, o_Pred_Valid=0, o_Prediction=1.
//  INIT: resolutions/flushes ignored, o_Mispredict=0.
//  Reset outputs: o_Ready=0, o_Stall=1, o_Pred_Valid=0, o_Mispredict=0, o_Prediction=1.
//  RUN lookup: combinational, zero latency. idx = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History.
//  o_Prediction = table[idx][1] (prediction = counter MSB).
//  o_Pred_Valid = i_DEC_Is_Branch & ~full & ~i_Flush; when 1, push {idx, o_Prediction} at the edge.
//  o_Stall = full | ~o_Ready. full = (count == INFLIGHT_DEPTH).
//  Resolution (i_ALU_Branch_Valid & ~empty):
//   - pop head; o_Mispredict = outcome != head.pred.
//   - table[head.idx] update is 2-bit saturating: taken -> +1, max 2'b11; not-taken -> -1, min 2'b00.
//  Resolution with FIFO empty: ignored, no table write, o_Mispredict=0.
//  Push+pop same cycle: both occur; count unchanged; permitted even when full (pop frees slot first).
//   - o_Stall still reflects pre-edge full.
//  Lookup + update of same idx, same cycle: lookup returns pre-update counter (bypass: see CONFIGURATION).
//  i_Flush: same-cycle resolution (train + mispredict) completes first; then FIFO emptied, count=0.
//   - A same-cycle lookup is dropped.
//  Pointers wrap modulo INFLIGHT_DEPTH; count width clog2(INFLIGHT_DEPTH)+1.
//  Table contents persist across flush; only reset re-initialises.
// CONFIGURATION
//  BP_UPDATE_BYPASS_EN defined: lookup idx == resolving head.idx same cycle -> o_Prediction = MSB of
//   post-update counter.
//  BP_UPDATE_BYPASS_EN undefined: lookup always reads pre-update table state.
// TESTING
//  1 Reset 1 cycle, release -> o_Ready=0 for 512 cycles (W=9), then 1.
//    First lookup PC=0x0, GHR=0 -> o_Prediction=1, o_Pred_Valid=1.
//  2 Lookup PC=0x10, GHR=0x004 (idx 0) then resolve not-taken x2 -> o_Mispredict=1 on first;
//    next lookup idx 0 -> prediction 0.
//  3 Train idx 5 taken x4 -> counter 2'b11 (saturates);
//    one not-taken -> prediction still 1; second not-taken -> 0.
//  4 Four lookups, no resolution -> o_Stall=1, 5th lookup o_Pred_Valid=0;
//    lookup + resolve same cycle while full -> accepted, count stays 4.
//  5 Three in flight, resolve with i_Flush=1 -> head trained, o_Mispredict per head, count=0;
//    next resolution with empty FIFO -> no table change.
//  6 Resolve idx 3 (2'b01, taken) + lookup idx 3 same cycle -> o_Prediction=1 with BP_UPDATE_BYPASS_EN, 0 without.
//  7 Assert i_Reset mid-RUN with 2 in flight -> next cycle o_Ready=0, FIFO empty, sweep restarts at 0.

Source files
------------

// File: rtl/bp_pattern_table_if.sv
// Branch-predictor pattern table bus: DEC lookup, EX resolution and flush signals.
// The master modport belongs to the pipeline and the slave modport to the table.
interface bp_pattern_table_if #(
  parameter int unsigned BPRED_WIDTH = 9
);
  logic                   i_DEC_Is_Branch;
  logic [31:0]            i_DEC_PC;
  logic [BPRED_WIDTH-1:0] i_Global_History;
  logic                   o_Prediction;
  logic                   o_Pred_Valid;
  logic                   o_Stall;
  logic                   o_Ready;
  logic                   i_ALU_Branch_Valid;
  logic                   i_ALU_Branch_Outcome;
  logic                   i_Flush;
  logic                   o_Mispredict;

  modport master (
    output i_DEC_Is_Branch, i_DEC_PC, i_Global_History,
    output i_ALU_Branch_Valid, i_ALU_Branch_Outcome, i_Flush,
    input  o_Prediction, o_Pred_Valid, o_Stall, o_Ready, o_Mispredict
  );

  modport slave (
    input  i_DEC_Is_Branch, i_DEC_PC, i_Global_History,
    input  i_ALU_Branch_Valid, i_ALU_Branch_Outcome, i_Flush,
    output o_Prediction, o_Pred_Valid, o_Stall, o_Ready, o_Mispredict
  );
endinterface

// File: rtl/bp_pattern_table.sv
// Gshare pattern history table with an in-flight FIFO that connects DEC lookups to EX training.
// Optional macro BP_UPDATE_BYPASS_EN forwards a same-cycle counter update to the lookup.
module bp_pattern_table #(
  parameter int unsigned BPRED_WIDTH    = 9,
  parameter int unsigned INFLIGHT_DEPTH = 4
) (
  input logic              i_Clk,
  input logic              i_Reset,
  bp_pattern_table_if.slave bus
);
  localparam int unsigned TABLE_SIZE = 1 << BPRED_WIDTH;
  localparam int unsigned PTR_W      = $clog2(INFLIGHT_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]             r_state;
  logic [0:0]             w_state_next;
  logic [BPRED_WIDTH-1:0] r_sweep_ptr;

  logic [1:0]             r_table [TABLE_SIZE];
  logic [BPRED_WIDTH-1:0] r_fifo_idx [INFLIGHT_DEPTH];
  logic                   r_fifo_pred [INFLIGHT_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  logic                   w_init;
  logic                   w_run;
  logic                   w_full;
  logic                   w_empty;
  logic [BPRED_WIDTH-1:0] w_idx;
  logic [BPRED_WIDTH-1:0] w_head_idx;
  logic                   w_head_pred;
  logic [1:0]             w_head_ctr;
  logic [1:0]             w_ctr_upd;
  logic [1:0]             w_lookup_ctr;
  logic                   w_pred;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_flush;
  logic                   w_tbl_we;
  logic [BPRED_WIDTH-1:0] w_tbl_waddr;
  logic [1:0]             w_tbl_wdata;
  logic                   w_unused_pc;

  // Reset masks the state-derived outputs so the reset cycle already shows reset values.
  assign w_init  = (r_state == S_INIT) & ~i_Reset;
  assign w_run   = (r_state == S_RUN) & ~i_Reset;
  assign w_full  = (r_count == CNT_W'(INFLIGHT_DEPTH));
  assign w_empty = (r_count == '0);

  assign w_idx       = bus.i_DEC_PC[BPRED_WIDTH+1:2] ^ bus.i_Global_History;
  assign w_unused_pc = ^{bus.i_DEC_PC[31:BPRED_WIDTH+2], bus.i_DEC_PC[1:0]};

  assign w_head_idx  = r_fifo_idx[r_rd_ptr];
  assign w_head_pred = r_fifo_pred[r_rd_ptr];
  assign w_head_ctr  = r_table[w_head_idx];

  assign w_pop   = w_run & bus.i_ALU_Branch_Valid & ~w_empty;
  assign w_flush = w_run & bus.i_Flush;

  // 2-bit saturating counter update for the resolving head entry.
  always_comb begin
    w_ctr_upd = w_head_ctr;
    if (bus.i_ALU_Branch_Outcome) begin
      if (w_head_ctr != 2'b11) w_ctr_upd = w_head_ctr + 2'b01;
    end else begin
      if (w_head_ctr != 2'b00) w_ctr_upd = w_head_ctr - 2'b01;
    end
  end

`ifdef BP_UPDATE_BYPASS_EN
  assign w_lookup_ctr = (w_pop && (w_head_idx == w_idx)) ? w_ctr_upd : r_table[w_idx];
`else
  assign w_lookup_ctr = r_table[w_idx];
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign w_pred = w_run ? w_lookup_ctr[1] : 1'b1;
  assign w_push = w_run & bus.i_DEC_Is_Branch & (~w_full | w_pop) & ~bus.i_Flush;

  assign bus.o_Prediction = w_pred;
  assign bus.o_Pred_Valid = w_push;
  assign bus.o_Stall      = w_full | ~w_run;
  assign bus.o_Ready      = w_run;
  assign bus.o_Mispredict = w_pop & (bus.i_ALU_Branch_Outcome != w_head_pred);

  always_comb begin
    w_state_next = r_state;
    if ((r_state == S_INIT) && (r_sweep_ptr == BPRED_WIDTH'(TABLE_SIZE - 1)))
      w_state_next = S_RUN;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state     <= S_INIT;
      r_sweep_ptr <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_INIT) r_sweep_ptr <= r_sweep_ptr + BPRED_WIDTH'(1);
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Single table write port: init sweep during INIT, training during RUN.
  assign w_tbl_we    = w_init | w_pop;
  assign w_tbl_waddr = w_init ? r_sweep_ptr : w_head_idx;
  assign w_tbl_wdata = w_init ? 2'b10 : w_ctr_upd;

  always_ff @(posedge i_Clk) begin
    if (w_tbl_we) r_table[w_tbl_waddr] <= w_tbl_wdata;
  end

  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr]  <= w_idx;
      r_fifo_pred[r_wr_ptr] <= w_pred;
    end
  end
endmodule

// File: tb/tb_bp_pattern_table.sv
// Directed scoreboard bench for bp_pattern_table: expectations are queued as each cycle is driven.
module tb_bp_pattern_table;
  localparam int unsigned W    = 9;
  localparam int unsigned D    = 4;
  localparam int unsigned NENT = 512;

  localparam int SIG_PRED  = 0;
  localparam int SIG_VALID = 1;
  localparam int SIG_STALL = 2;
  localparam int SIG_READY = 3;
  localparam int SIG_MIS   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_pattern_table_if #(.BPRED_WIDTH(W)) bus ();

  bp_pattern_table #(.BPRED_WIDTH(W), .INFLIGHT_DEPTH(D)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  string q_tag[$];
  int    q_sig[$];
  logic  q_exp[$];

  logic [1:0] m_tbl [NENT];
  int         m_idx[$];
  logic       m_pred[$];
  int         m_init_left = 0;

  function automatic logic [1:0] sat(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic observe(input int sig);
    case (sig)
      SIG_PRED:  return bus.o_Prediction;
      SIG_VALID: return bus.o_Pred_Valid;
      SIG_STALL: return bus.o_Stall;
      SIG_READY: return bus.o_Ready;
      SIG_MIS:   return bus.o_Mispredict;
      default:   return 1'bx;
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sig, input logic v);
    q_tag.push_back(tag);
    q_sig.push_back(sig);
    q_exp.push_back(v);
  endtask

  // Apply one cycle of inputs and queue the outputs the model predicts for it.
  task automatic drive(input logic rs, input logic br, input logic [31:0] pc,
                       input logic [W-1:0] ghr, input logic rv, input logic ro,
                       input logic fl);
    int         idx;
    int         hidx;
    logic       full;
    logic       pop;
    logic       pv;
    logic       hpred;
    logic [1:0] look;
    logic [1:0] upd;
    hidx  = 0;
    hpred = 1'b0;
    upd   = 2'b00;
    rst                      = rs;
    bus.i_DEC_Is_Branch      = br;
    bus.i_DEC_PC             = pc;
    bus.i_Global_History     = ghr;
    bus.i_ALU_Branch_Valid   = rv;
    bus.i_ALU_Branch_Outcome = ro;
    bus.i_Flush              = fl;
    if (rs) begin
      expect_sig("rst_pred", SIG_PRED, 1'b1);
      expect_sig("rst_valid", SIG_VALID, 1'b0);
      expect_sig("rst_stall", SIG_STALL, 1'b1);
      expect_sig("rst_ready", SIG_READY, 1'b0);
      expect_sig("rst_mis", SIG_MIS, 1'b0);
      for (int i = 0; i < int'(NENT); i++) m_tbl[i] = 2'b10;
      m_idx.delete();
      m_pred.delete();
      m_init_left = NENT;
    end else if (m_init_left > 0) begin
      expect_sig("init_pred", SIG_PRED, 1'b1);
      expect_sig("init_valid", SIG_VALID, 1'b0);
      expect_sig("init_stall", SIG_STALL, 1'b1);
      expect_sig("init_ready", SIG_READY, 1'b0);
      expect_sig("init_mis", SIG_MIS, 1'b0);
      m_init_left--;
    end else begin
      idx  = int'(pc[W+1:2] ^ ghr);
      full = (m_idx.size() == D);
      pop  = rv && (m_idx.size() > 0);
      look = m_tbl[idx];
      if (pop) begin
        hidx  = m_idx[0];
        hpred = m_pred[0];
        upd   = sat(m_tbl[hidx], ro);
`ifdef BP_UPDATE_BYPASS_EN
        if (hidx == idx) look = upd;
`endif
      end
      pv = br && (!full || pop) && !fl;
      expect_sig("run_pred", SIG_PRED, look[1]);
      expect_sig("run_valid", SIG_VALID, pv);
      expect_sig("run_stall", SIG_STALL, full);
      expect_sig("run_ready", SIG_READY, 1'b1);
      expect_sig("run_mis", SIG_MIS, pop && (ro != hpred));
      if (pop) begin
        m_tbl[hidx] = upd;
        void'(m_idx.pop_front());
        void'(m_pred.pop_front());
      end
      if (pv) begin
        m_idx.push_back(idx);
        m_pred.push_back(look[1]);
      end
      if (fl) begin
        m_idx.delete();
        m_pred.delete();
      end
    end
  endtask

  // Compare queued expectations mid-cycle, then advance past the next rising edge.
  task automatic tick();
    string tag;
    int    sig;
    logic  ev;
    logic  obs;
    @(negedge clk);
    while (q_tag.size() > 0) begin
      tag = q_tag.pop_front();
      sig = q_sig.pop_front();
      ev  = q_exp.pop_front();
      obs = observe(sig);
      n_cmp++;
      assert (obs === ev) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, ev);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic look_pc(input logic [31:0] pc);
    drive(1'b0, 1'b1, pc, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic outcome);
    drive(1'b0, 1'b0, 32'h0, '0, 1'b1, outcome, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with noisy inputs, then the full init sweep with requests ignored.
    drive(1'b1, 1'b1, 32'h0, '0, 1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < int'(NENT); i++) begin
      drive(1'b0, 1'b1, 32'h0, '0, 1'b1, 1'b0, 1'b1);
      tick();
    end

    // First lookup after init: weakly taken.
    look_pc(32'h0);
    expect_sig("s1_ready", SIG_READY, 1'b1);
    expect_sig("s1_pred", SIG_PRED, 1'b1);
    expect_sig("s1_valid", SIG_VALID, 1'b1);
    tick();

    // PC 0x10 ^ GHR 0x004 hits index 0; two not-taken resolutions flip it.
    drive(1'b0, 1'b1, 32'h10, 9'h004, 1'b0, 1'b0, 1'b0);
    expect_sig("s2_valid", SIG_VALID, 1'b1);
    tick();
    resolve(1'b0);
    expect_sig("s2_mis_first", SIG_MIS, 1'b1);
    tick();
    resolve(1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h10, 9'h004, 1'b0, 1'b0, 1'b0);
    expect_sig("s2_pred_idx0", SIG_PRED, 1'b0);
    tick();
    resolve(1'b0);
    tick();

    // Index 5: saturate at strongly taken, then walk back down.
    for (int i = 0; i < 4; i++) begin
      look_pc(32'h14);
      tick();
      resolve(1'b1);
      expect_sig("s3_train_mis", SIG_MIS, 1'b0);
      tick();
    end
    look_pc(32'h14);
    expect_sig("s3_sat_pred", SIG_PRED, 1'b1);
    tick();
    resolve(1'b0);
    expect_sig("s3_nt1_mis", SIG_MIS, 1'b1);
    tick();
    look_pc(32'h14);
    expect_sig("s3_after_nt1", SIG_PRED, 1'b1);
    tick();
    resolve(1'b0);
    tick();
    look_pc(32'h14);
    expect_sig("s3_after_nt2", SIG_PRED, 1'b0);
    tick();
    resolve(1'b0);
    tick();

    // Fill the FIFO, reject a fifth lookup, then push and pop together while full.
    for (int i = 0; i < 4; i++) begin
      look_pc(32'h100 + 32'(4 * i));
      tick();
    end
    look_pc(32'h200);
    expect_sig("s4_full_stall", SIG_STALL, 1'b1);
    expect_sig("s4_full_reject", SIG_VALID, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h200, '0, 1'b1, 1'b1, 1'b0);
    expect_sig("s4_push_pop_valid", SIG_VALID, 1'b1);
    expect_sig("s4_push_pop_stall", SIG_STALL, 1'b1);
    tick();
    idle();
    expect_sig("s4_still_full", SIG_STALL, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      resolve(1'b1);
      tick();
    end
    idle();
    expect_sig("s4_drained", SIG_STALL, 1'b0);
    tick();

    // Flush with three in flight: head trained, lookup dropped, FIFO emptied.
    look_pc(32'h1C);
    tick();
    look_pc(32'h20);
    tick();
    look_pc(32'h24);
    tick();
    drive(1'b0, 1'b1, 32'h30, '0, 1'b1, 1'b0, 1'b1);
    expect_sig("s5_flush_mis", SIG_MIS, 1'b1);
    expect_sig("s5_flush_drop", SIG_VALID, 1'b0);
    tick();
    idle();
    expect_sig("s5_empty", SIG_STALL, 1'b0);
    tick();
    resolve(1'b1);
    expect_sig("s5_empty_resolve", SIG_MIS, 1'b0);
    tick();
    look_pc(32'h1C);
    expect_sig("s5_head_trained", SIG_PRED, 1'b0);
    tick();
    look_pc(32'h20);
    expect_sig("s5_flushed_untrained", SIG_PRED, 1'b1);
    tick();
    resolve(1'b1);
    tick();
    resolve(1'b1);
    tick();

    // Index 3 at weakly not-taken: same-cycle taken update and lookup.
    look_pc(32'hC);
    tick();
    resolve(1'b0);
    tick();
    look_pc(32'hC);
    expect_sig("s6_pred_wnt", SIG_PRED, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'hC, '0, 1'b1, 1'b1, 1'b0);
`ifdef BP_UPDATE_BYPASS_EN
    expect_sig("s6_same_idx", SIG_PRED, 1'b1);
`else
    expect_sig("s6_same_idx", SIG_PRED, 1'b0);
`endif
    expect_sig("s6_mis", SIG_MIS, 1'b1);
    tick();
    resolve(1'b1);
    tick();

    // Reset mid-run with two in flight: init restarts, FIFO and table reinitialised.
    look_pc(32'h28);
    tick();
    look_pc(32'h2C);
    tick();
    drive(1'b1, 1'b1, 32'h0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0, '0, 1'b1, 1'b0, 1'b0);
    expect_sig("s7_ready0", SIG_READY, 1'b0);
    expect_sig("s7_init_mis", SIG_MIS, 1'b0);
    tick();
    for (int i = 1; i < int'(NENT); i++) begin
      drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    resolve(1'b0);
    expect_sig("s7_ready1", SIG_READY, 1'b1);
    expect_sig("s7_fifo_empty", SIG_MIS, 1'b0);
    expect_sig("s7_no_stall", SIG_STALL, 1'b0);
    tick();
    look_pc(32'h0);
    expect_sig("s7_reinit", SIG_PRED, 1'b1);
    tick();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
